rx_lane_sync_ctrl: RTL

Per-lane receive symbol-lock and polarity controller for the PCIe display link.
- Watches the raw 10-bit symbol stream ahead of the lane decoder and acquires/loses symbol synchronisation from COM and invalid-code events.
- Drives the lane's `Synced` and `InvertTxPolarity` controls.
- One instance per lane, between the lane input and the Rx lane datapath.

---
 rtl/rx_lane_sync_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rx_lane_sync_ctrl.sv
// Per-lane Rx symbol-lock FSM with optional TS-identifier polarity inversion (macro RX_SYNC_POLARITY_EN).
// Latency: every output is registered and reflects the symbol sampled one Clk earlier.
// Backpressure: none; one symbol is consumed on every Clk.
module rx_lane_sync_ctrl #(
    parameter int SYNC_COMMAS = 4,
    parameter int LOSS_ERRS   = 4,
    parameter int GOOD_RUN    = 16,
    parameter int POL_TS_CNT  = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] LinkIn,
    input  logic       CodeErr,
    input  logic       PolarityClear,
    output logic       Synced,
    output logic       InvertTxPolarity,
    output logic       SyncLost,
    output logic [2:0] ErrCount
);
    localparam logic [1:0] UNSYNC = 2'd0;
    localparam logic [1:0] ACQ    = 2'd1;
    localparam logic [1:0] SYNC   = 2'd2;

    localparam logic [3:0] SyncCommas = SYNC_COMMAS[3:0];
    localparam logic [2:0] LossErrs   = LOSS_ERRS[2:0];
    localparam logic [7:0] GoodRun    = GOOD_RUN[7:0];

    logic [1:0] state, stateNext;
    logic [3:0] commaCnt, commaCntNext;
    logic [7:0] goodRun, goodRunNext;
    logic [2:0] errNext;
    logic       syncLostNext;
    logic       lossEvt;
    logic       polFlip;
    logic [9:0] linkData;
    logic       isCom;

    assign linkData = LinkIn ^ {10{InvertTxPolarity}};
    assign isCom    = (linkData == 10'h0FA) || (linkData == 10'h305);

    always_comb begin
        stateNext    = state;
        commaCntNext = commaCnt;
        goodRunNext  = goodRun;
        errNext      = ErrCount;
        syncLostNext = 1'b0;
        lossEvt      = 1'b0;
        case (state)
            UNSYNC: begin
                if (isCom && !CodeErr) begin
                    if (SyncCommas == 4'd1) begin
                        stateNext    = SYNC;
                        commaCntNext = 4'd0;
                        errNext      = 3'd0;
                        goodRunNext  = 8'd0;
                    end else begin
                        stateNext    = ACQ;
                        commaCntNext = 4'd1;
                    end
                end
            end
            ACQ: begin
                if (CodeErr) begin
                    stateNext    = UNSYNC;
                    commaCntNext = 4'd0;
                end else if (isCom) begin
                    if (commaCnt + 4'd1 == SyncCommas) begin
                        stateNext    = SYNC;
                        commaCntNext = 4'd0;
                        errNext      = 3'd0;
                        goodRunNext  = 8'd0;
                    end else begin
                        commaCntNext = commaCnt + 4'd1;
                    end
                end
            end
            SYNC: begin
                if (CodeErr) begin
                    goodRunNext = 8'd0;
                    if (ErrCount + 3'd1 == LossErrs) begin
                        lossEvt      = 1'b1;
                        stateNext    = UNSYNC;
                        errNext      = 3'd0;
                        syncLostNext = 1'b1;
                    end else begin
                        errNext = ErrCount + 3'd1;
                    end
                end else if (goodRun != GoodRun) begin
                    // Run saturates at GoodRun only while there is nothing left to forgive
                    if ((goodRun + 8'd1 == GoodRun) && (ErrCount != 3'd0)) begin
                        errNext     = ErrCount - 3'd1;
                        goodRunNext = 8'd0;
                    end else begin
                        goodRunNext = goodRun + 8'd1;
                    end
                end
                if (polFlip && !lossEvt) begin
                    stateNext   = UNSYNC;
                    errNext     = 3'd0;
                    goodRunNext = 8'd0;
                end
            end
            default: stateNext = UNSYNC;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= UNSYNC;
            commaCnt <= 4'd0;
            goodRun  <= 8'd0;
            ErrCount <= 3'd0;
            SyncLost <= 1'b0;
            Synced   <= 1'b0;
        end else begin
            state    <= stateNext;
            commaCnt <= commaCntNext;
            goodRun  <= goodRunNext;
            ErrCount <= errNext;
            SyncLost <= syncLostNext;
            Synced   <= (stateNext == SYNC);
        end
    end

`ifdef RX_SYNC_POLARITY_EN
    localparam logic [2:0] PolTsCnt = POL_TS_CNT[2:0];

    logic [2:0] symIdx, symIdxNow;
    logic [2:0] polCnt;
    logic       isTsId, tsNormal, tsInverted;

    // Index of the symbol on the wire now: COM is position 0 of an ordered set
    assign symIdxNow  = isCom ? 3'd0 : ((symIdx == 3'd7) ? 3'd7 : symIdx + 3'd1);
    assign isTsId     = (state == SYNC) && (symIdxNow == 3'd6);
    assign tsNormal   = isTsId && ((linkData == 10'h155) || (linkData == 10'h295));
    assign tsInverted = isTsId && ((linkData == 10'h2AA) || (linkData == 10'h16A));
    assign polFlip    = tsInverted && !PolarityClear && (polCnt + 3'd1 == PolTsCnt);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            symIdx           <= 3'd0;
            polCnt           <= 3'd0;
            InvertTxPolarity <= 1'b0;
        end else begin
            symIdx <= (stateNext == SYNC) ? symIdxNow : 3'd0;
            if (PolarityClear) begin
                InvertTxPolarity <= 1'b0;
                polCnt           <= 3'd0;
            end else if (stateNext != SYNC) begin
                polCnt <= 3'd0;
                if (polFlip && !lossEvt) begin
                    InvertTxPolarity <= ~InvertTxPolarity;
                end
            end else if (tsNormal) begin
                polCnt <= 3'd0;
            end else if (tsInverted) begin
                polCnt <= polCnt + 3'd1;
            end
        end
    end
`else
    logic unusedPol;

    assign polFlip          = 1'b0;
    assign InvertTxPolarity = 1'b0;
    assign unusedPol        = PolarityClear ^ (POL_TS_CNT != 0);
`endif

endmodule
